// File: rtl/m68k_bus_target_pkg.sv
// Shared types and constants for the 68000 bus target: FSM state encoding and
// the function code that marks interrupt-acknowledge cycles.
package m68k_bus_target_pkg;

  localparam logic [2:0] FC_IACK = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_ACKED,
    ST_ERROR
  } state_t;

  function automatic logic strobe_active(input logic uds_n, input logic lds_n);
    return !uds_n || !lds_n;
  endfunction

endpackage

// File: rtl/m68k_bus_target_if.sv
// 68000 responder-side bus plus the internal request/acknowledge port.
// master = CPU wrapper and backend memory, slave = the bus target.
interface m68k_bus_target_if;

  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        rw_n;
  logic [2:0]  fc;
  logic [23:1] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        dout_oe;
  logic        dtack_n;
  logic        berr;

  logic        req;
  logic        we;
  logic [1:0]  be;
  logic [7:0]  baddr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;

  modport master (
    output as_n, uds_n, lds_n, rw_n, fc, addr, din, rdata, ack,
    input  dout, dout_oe, dtack_n, berr, req, we, be, baddr, wdata
  );

  modport slave (
    input  as_n, uds_n, lds_n, rw_n, fc, addr, din, rdata, ack,
    output dout, dout_oe, dtack_n, berr, req, we, be, baddr, wdata
  );

endinterface

// File: rtl/m68k_addr_decode.sv
// Address window comparator: hit when the byte address matches ADDR_BASE on
// every bit set in ADDR_MASK. Byte-lane bit 0 never takes part.
module m68k_addr_decode #(
  parameter logic [23:0] ADDR_BASE = 24'hFF8800,
  parameter logic [23:0] ADDR_MASK = 24'hFFFF00
) (
  input  logic [23:1] addr,
  output logic        hit
);

  localparam logic [23:0] MASK = {ADDR_MASK[23:1], 1'b0};

  assign hit = (({addr, 1'b0} & MASK) == (ADDR_BASE & MASK));

endmodule

// File: rtl/m68k_bus_target.sv
// 68000 asynchronous bus responder: claims cycles in an address window, runs
// one req/ack transaction on the backend and answers with DTACK or BERR.
module m68k_bus_target
  import m68k_bus_target_pkg::*;
#(
  parameter logic [23:0] ADDR_BASE   = 24'hFF8800,
  parameter logic [23:0] ADDR_MASK   = 24'hFFFF00,
  parameter int          WAIT_STATES = 0,
  parameter int          TIMEOUT     = 32,
  parameter bit          SUPER_ONLY  = 1'b0
) (
  input logic              clk,
  input logic              reset,
  input logic              phi1,
  input logic              phi2,
  m68k_bus_target_if.slave bus
);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic [7:0]  baddr_q, baddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        dtack_n_q, dtack_n_d;
  logic        berr_q, berr_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        armed_q, armed_d;

  logic hit;
  logic sel;
  logic tick;

  m68k_addr_decode #(
    .ADDR_BASE(ADDR_BASE),
    .ADDR_MASK(ADDR_MASK)
  ) u_decode (
    .addr(bus.addr),
    .hit (hit)
  );

  // Phases never overlap on a healthy bus; an overlap is treated as a glitch.
  assign tick = phi2 && !phi1;
  assign sel  = !bus.as_n && strobe_active(bus.uds_n, bus.lds_n) &&
                (bus.fc != FC_IACK) && hit;

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned; a missed default in always_comb would infer a latch.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    baddr_d   = baddr_q;
    wdata_d   = wdata_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    dtack_n_d = dtack_n_q;
    berr_d    = berr_q;
    tcnt_d    = tcnt_q;
    wcnt_d    = wcnt_q;
    armed_d   = armed_q;

    if (tick && bus.as_n) armed_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        // A request left over from an aborted or timed-out cycle is absorbed
        // here and blocks new cycles until the backend answers it.
        if (req_q && bus.ack) req_d = 1'b0;
        if (tick && sel && armed_q && !req_q) begin
          armed_d = 1'b0;
          we_d    = !bus.rw_n;
          be_d    = {!bus.uds_n, !bus.lds_n};
          baddr_d = bus.addr[8:1];
          wdata_d = bus.din;
          tcnt_d  = '0;
          if (SUPER_ONLY && !bus.fc[2]) begin
            state_d = ST_ERROR;
            berr_d  = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            req_d   = 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        if (bus.ack) begin
          req_d  = 1'b0;
          wcnt_d = '0;
          if (!we_q) dout_d = bus.rdata;
          if (tick && bus.as_n)  state_d = ST_IDLE;
          else if (WAIT_STATES > 0) state_d = ST_WAIT;
          else                   state_d = ST_ACKED;
        end else if (tick) begin
          if (bus.as_n) begin
            state_d = ST_IDLE;
          end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
            state_d = ST_ERROR;
            berr_d  = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end

      ST_WAIT: begin
        if (tick) begin
          if (bus.as_n)                             state_d = ST_IDLE;
          else if (wcnt_q == 4'(WAIT_STATES - 1))   state_d = ST_ACKED;
          else                                      wcnt_d  = wcnt_q + 4'd1;
        end
      end

      ST_ACKED: begin
        // DTACK goes out on the first phi2 spent here, then holds until the
        // CPU negates AS.
        if (tick) begin
          if (dtack_n_q) begin
            if (bus.as_n) begin
              state_d = ST_IDLE;
            end else begin
              dtack_n_d = 1'b0;
              oe_d      = !we_q;
            end
          end else if (bus.as_n) begin
            dtack_n_d = 1'b1;
            oe_d      = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end

      ST_ERROR: begin
        if (req_q && bus.ack) req_d = 1'b0;
        if (tick && bus.as_n) begin
          berr_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous and returns all outputs at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      baddr_q   <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      dtack_n_q <= 1'b1;
      berr_q    <= 1'b0;
      tcnt_q    <= '0;
      wcnt_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      be_q      <= be_d;
      baddr_q   <= baddr_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      dtack_n_q <= dtack_n_d;
      berr_q    <= berr_d;
      tcnt_q    <= tcnt_d;
      wcnt_q    <= wcnt_d;
      armed_q   <= armed_d;
    end
  end

  assign bus.req     = req_q;
  assign bus.we      = we_q;
  assign bus.be      = be_q;
  assign bus.baddr   = baddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.dout    = dout_q;
  assign bus.dout_oe = oe_q;
  assign bus.dtack_n = dtack_n_q;
  assign bus.berr    = berr_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Bench for m68k_bus_target: three instances (zero wait, three waits,
// supervisor-only) share one CPU stimulus and are checked against an event model.
module tb_m68k_bus_target;

  localparam int          TIMEOUT   = 32;
  localparam logic [46:0] RESET_VEC = {1'b1, 46'b0};

  logic clk, reset, phi1, phi2;

  logic        as_n, uds_n, lds_n, rw_n;
  logic [2:0]  fc;
  logic [23:1] addr;
  logic [15:0] din, rdata;
  logic        ack_en;
  int          ack_delay;
  logic [2:0]  ack_drv;
  logic [23:0] byte_a;

  m68k_bus_target_if bus0 ();
  m68k_bus_target_if bus3 ();
  m68k_bus_target_if buss ();

  assign bus0.as_n = as_n, bus0.uds_n = uds_n, bus0.lds_n = lds_n, bus0.rw_n = rw_n,
         bus0.fc = fc, bus0.addr = addr, bus0.din = din, bus0.rdata = rdata, bus0.ack = ack_drv[0];
  assign bus3.as_n = as_n, bus3.uds_n = uds_n, bus3.lds_n = lds_n, bus3.rw_n = rw_n,
         bus3.fc = fc, bus3.addr = addr, bus3.din = din, bus3.rdata = rdata, bus3.ack = ack_drv[1];
  assign buss.as_n = as_n, buss.uds_n = uds_n, buss.lds_n = lds_n, buss.rw_n = rw_n,
         buss.fc = fc, buss.addr = addr, buss.din = din, buss.rdata = rdata, buss.ack = ack_drv[2];

  m68k_bus_target #(.WAIT_STATES(0), .TIMEOUT(TIMEOUT), .SUPER_ONLY(1'b0)) dut0 (
    .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2), .bus(bus0));
  m68k_bus_target #(.WAIT_STATES(3), .TIMEOUT(TIMEOUT), .SUPER_ONLY(1'b0)) dut3 (
    .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2), .bus(bus3));
  m68k_bus_target #(.WAIT_STATES(0), .TIMEOUT(TIMEOUT), .SUPER_ONLY(1'b1)) duts (
    .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2), .bus(buss));

  logic [46:0] obs [3];
  logic [2:0]  req_v, dtack_v, berr_v;
  assign obs[0] = {bus0.dtack_n, bus0.berr, bus0.req, bus0.dout_oe, bus0.we, bus0.be,
                   bus0.baddr, bus0.wdata, bus0.dout};
  assign obs[1] = {bus3.dtack_n, bus3.berr, bus3.req, bus3.dout_oe, bus3.we, bus3.be,
                   bus3.baddr, bus3.wdata, bus3.dout};
  assign obs[2] = {buss.dtack_n, buss.berr, buss.req, buss.dout_oe, buss.we, buss.be,
                   buss.baddr, buss.wdata, buss.dout};
  assign req_v   = {buss.req, bus3.req, bus0.req};
  assign dtack_v = {buss.dtack_n, bus3.dtack_n, bus0.dtack_n};
  assign berr_v  = {buss.berr, bus3.berr, bus0.berr};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Phases alternate each clk and settle before the falling edge.
  initial begin
    clk = 0; phi1 = 0; phi2 = 1;
    forever begin
      #5 clk = 1;
      #4 {phi1, phi2} = {phi2, phi1};
      #1 clk = 0;
    end
  end

  // Backend: one-clk ack pulse ack_delay clks after req is first seen.
  initial begin
    int c[3];
    ack_drv = '0;
    for (int i = 0; i < 3; i++) c[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (ack_drv[i]) begin
          ack_drv[i] = 1'b0;
          c[i] = 0;
        end else if (!req_v[i]) begin
          c[i] = 0;
        end else if (ack_en) begin
          if (c[i] >= ack_delay) ack_drv[i] = 1'b1;
          else c[i]++;
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  function automatic int ws_of(input int i);
    return (i == 1) ? 3 : 0;
  endfunction

  function automatic bit in_window(input logic [23:1] a);
    logic [23:0] b;
    b = {a, 1'b0};
    return (b >= 24'hFF8800) && (b <= 24'hFF88FF);
  endfunction

  bit          m_req[3], m_dtack[3], m_berr[3], m_oe[3], m_we[3];
  logic [1:0]  m_be[3];
  logic [7:0]  m_baddr[3];
  logic [15:0] m_wdata[3], m_dout[3];
  bit          act[3], acked[3], errd[3], armed[3];
  int          cnt[3], nsel[3];

  always @(posedge clk) begin
    bit req_pre, acked_pre, armed_pre;
    for (int i = 0; i < 3; i++) begin
      req_pre = m_req[i]; acked_pre = acked[i]; armed_pre = armed[i];
      if (reset) begin
        m_req[i] = 0; m_dtack[i] = 0; m_berr[i] = 0; m_oe[i] = 0; m_we[i] = 0;
        m_be[i] = '0; m_baddr[i] = '0; m_wdata[i] = '0; m_dout[i] = '0;
        act[i] = 0; acked[i] = 0; errd[i] = 0; armed[i] = 0;
      end else begin
        if (m_req[i] && ack_drv[i]) begin
          m_req[i] = 0;
          if (act[i] && !acked[i] && !errd[i]) begin
            acked[i] = 1; cnt[i] = 0;
            if (!m_we[i]) m_dout[i] = rdata;
          end
        end
        if (phi2) begin
          if (as_n) armed[i] = 1;
          if (!act[i]) begin
            if (!as_n && armed_pre && !req_pre && (!uds_n || !lds_n) &&
                fc != 3'b111 && in_window(addr)) begin
              armed[i] = 0; act[i] = 1; acked[i] = 0; errd[i] = 0; nsel[i] = 0;
              m_we[i] = !rw_n; m_be[i] = {!uds_n, !lds_n};
              m_baddr[i] = addr[8:1]; m_wdata[i] = din;
              if (i == 2 && !fc[2]) begin errd[i] = 1; m_berr[i] = 1; end
              else m_req[i] = 1;
            end
          end else if (as_n) begin
            m_dtack[i] = 0; m_oe[i] = 0; m_berr[i] = 0; act[i] = 0;
          end else if (acked_pre) begin
            if (!m_dtack[i]) begin
              cnt[i]++;
              if (cnt[i] == ws_of(i) + 1) begin m_dtack[i] = 1; m_oe[i] = !m_we[i]; end
            end
          end else if (!acked[i] && !errd[i]) begin
            nsel[i]++;
            if (nsel[i] == TIMEOUT) begin errd[i] = 1; m_berr[i] = 1; end
          end
        end
      end
    end
    #2;
    for (int i = 0; i < 3; i++)
      check($sformatf("dut%0d_cycle", i), obs[i],
            {!m_dtack[i], m_berr[i], m_req[i], m_oe[i], m_we[i], m_be[i],
             m_baddr[i], m_wdata[i], m_dout[i]});
  end

  // ---------------- directed stimulus ----------------
  int         dt_at[3], berr_at[3];
  logic [2:0] req_seen;

  task automatic align_phi1();
    do @(negedge clk); while (!phi1);
  endtask

  // dt_at/berr_at: phi2 clocks after the selecting phi2 when each DUT answered.
  task automatic bus_cycle(input logic [23:0] ba, input logic rw, input logic u_n,
                           input logic l_n, input logic [2:0] f, input logic [15:0] d,
                           input int hold);
    int n;
    align_phi1();
    byte_a = ba;
    addr = byte_a[23:1]; rw_n = rw; fc = f; din = d;
    as_n = 0; uds_n = u_n; lds_n = l_n;
    n = 0; req_seen = '0;
    for (int i = 0; i < 3; i++) begin dt_at[i] = -1; berr_at[i] = -1; end
    repeat (hold) begin
      @(posedge clk);
      if (phi2) n++;
      #1;
      req_seen |= req_v;
      for (int i = 0; i < 3; i++) begin
        if (dt_at[i] < 0 && !dtack_v[i]) dt_at[i] = n - 1;
        if (berr_at[i] < 0 && berr_v[i]) berr_at[i] = n - 1;
      end
    end
    @(negedge clk);
    as_n = 1; uds_n = 1; lds_n = 1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    reset = 1; as_n = 1; uds_n = 1; lds_n = 1; rw_n = 1; fc = 3'b101;
    addr = '0; din = '0; rdata = '0; ack_en = 1; ack_delay = 2;
    repeat (4) @(negedge clk);
    check("reset_outputs", obs[0], RESET_VEC);
    reset = 0;
    repeat (4) @(negedge clk);

    rdata = 16'hBEEF;
    bus_cycle(24'hFF8804, 1'b1, 1'b0, 1'b0, 3'b101, 16'h0000, 20);
    check("rd_dtack_ws0", dt_at[0], 2);
    check("rd_dtack_ws3", dt_at[1], 5);
    check("rd_dtack_super", dt_at[2], 2);
    check("rd_dout", bus0.dout, 16'hBEEF);
    check("rd_baddr", bus0.baddr, 8'h02);
    check("rd_be", bus0.be, 2'b11);
    check("rd_released", bus0.dtack_n, 1'b1);

    bus_cycle(24'hFF8811, 1'b0, 1'b1, 1'b0, 3'b101, 16'h00A5, 20);
    check("wr_we", bus0.we, 1'b1);
    check("wr_be", bus0.be, 2'b01);
    check("wr_wdata", bus0.wdata, 16'h00A5);
    check("wr_baddr", bus0.baddr, 8'h08);
    check("wr_req", req_seen[0], 1'b1);
    check("wr_dtack", dt_at[0], 2);
    check("wr_dout_kept", bus0.dout, 16'hBEEF);

    bus_cycle(24'hFF8900, 1'b1, 1'b0, 1'b0, 3'b101, 16'h0000, 20);
    check("miss_req", req_seen, 3'b000);
    check("miss_dtack", dt_at[0], -1);
    check("miss_berr", berr_at[0], -1);

    bus_cycle(24'hFF8804, 1'b1, 1'b0, 1'b0, 3'b111, 16'h0000, 20);
    check("iack_req", req_seen, 3'b000);
    check("iack_dtack", dt_at[0], -1);

    bus_cycle(24'hFF8804, 1'b1, 1'b0, 1'b0, 3'b001, 16'h0000, 20);
    check("user_berr", berr_at[2], 0);
    check("user_noreq", req_seen[2], 1'b0);
    check("user_ok_other", dt_at[0], 2);

    ack_en = 0;
    bus_cycle(24'hFF8806, 1'b1, 1'b0, 1'b0, 3'b101, 16'h0000, 80);
    check("to_berr_phi2", berr_at[0], TIMEOUT);
    check("to_no_dtack", dt_at[0], -1);
    check("to_berr_clear", bus0.berr, 1'b0);
    check("to_req_held", bus0.req, 1'b1);
    rdata = 16'h1234;
    ack_en = 1;
    repeat (8) @(negedge clk);
    check("late_ack_req", bus0.req, 1'b0);
    check("late_ack_dout", bus0.dout, 16'hBEEF);

    ack_en = 0;
    align_phi1();
    byte_a = 24'hFF8808;
    addr = byte_a[23:1]; rw_n = 1; fc = 3'b101; as_n = 0; uds_n = 0; lds_n = 0;
    repeat (6) @(negedge clk);
    check("mid_req", bus0.req, 1'b1);
    reset = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) check($sformatf("mid_reset%0d", i), obs[i], RESET_VEC);
    @(negedge clk);
    reset = 0; as_n = 1; uds_n = 1; lds_n = 1; ack_en = 1;
    repeat (6) @(negedge clk);

    rdata = 16'h5A5A;
    bus_cycle(24'hFF88FE, 1'b1, 1'b0, 1'b0, 3'b101, 16'h0000, 20);
    check("top_dtack", dt_at[0], 2);
    check("top_baddr", bus0.baddr, 8'h7F);
    check("top_dout", bus0.dout, 16'h5A5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
